pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register with valid/ready flow control, stall back-pressure, synchronous flush and optional skid buffering. It replaces fixed-field, handshake-free stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. Control and data payloads are concatenated by the instantiating stage. A flushed or empty stage always presents zeroed control, so a bubble can never write registers or memory.

## Interface
- `DATA_W`, default 32: payload width that is not cleared on bubble (ALU result, read data, PC+4, etc.).
- `CTRL_W`, default 5: control payload width, forced to 0 whenever the output is invalid.
- `SKID`, default 1: 1 = two-entry skid buffer with registered `In_Ready`; 0 = single entry with combinational `In_Ready`.
- `Clk`  in  1: sole clock, rising-edge active.
- `Reset_n`  in  1: asynchronous, active-low reset.
- `Flush`  in  1: synchronous discard of all held entries.
- `In_Valid`  in  1: upstream has a beat.
- `In_Ready`  out  1: stage can accept a beat.
- `In_Ctrl`  in  CTRL_W: control payload.
- `In_Data`  in  DATA_W: data payload.
- `Out_Valid`  out  1: beat available downstream.
- `Out_Ready`  in  1: downstream accepts (0 = stall).
- `Out_Ctrl`  out  CTRL_W: control payload; 0 when `Out_Valid`=0.
- `Out_Data`  out  DATA_W: data payload; holds its last value when invalid.
- `Occupancy`  out  2: number of entries held (0–2).

## Operation
- Transfer rules: in_fire = `In_Valid` & `In_Ready`; out_fire = `Out_Valid` & `Out_Ready`.
- State machine for SKID=1 (states EMPTY, FULL, SKID):
  - EMPTY: in_fire moves to FULL and loads the main entry.
  - FULL with in_fire & out_fire: stays FULL and loads the main entry.
  - FULL with in_fire only: moves to SKID and loads the skid entry.
  - FULL with out_fire only: moves to EMPTY.
  - SKID: out_fire moves to FULL, main entry takes the skid entry. `In_Ready`=0 in this state, so no in_fire occurs.
- SKID=0: states EMPTY and FULL only. `In_Ready` = `Reset_n` & (~`Out_Valid` | `Out_Ready`), so simultaneous in_fire and out_fire keeps the stage FULL.
- `Flush` has priority over every transition. The next state is EMPTY and all entries are invalidated. A beat that fires in the flush cycle is dropped.
- `Out_Ctrl` = main ctrl & {CTRL_W{`Out_Valid`}}.
- `Out_Data` is not cleared by `Flush`.
- Payload order is preserved; there is no reordering and no duplication.
- `Occupancy` reads 0 in EMPTY, 1 in FULL, 2 in SKID.

## Timing
- Latency: 1 cycle. A beat accepted at edge N is visible on `Out_*` after edge N.
- Throughput: 1 beat/cycle when `Out_Ready` is held at 1.
- SKID=1: `In_Ready` is registered, with no combinational path from `Out_Ready`. It deasserts the cycle after a stall begins, and the skid entry absorbs the beat already in flight.
- Outputs while `Reset_n` is low: `Out_Valid`=0, `Out_Ctrl`=0, `Out_Data`=0, `Occupancy`=0, `In_Ready`=0.
- State while `Reset_n` is low: EMPTY.
- First cycle after deassertion: `In_Ready`=1.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.
- `Flush` and stall together: `Flush` wins. The cycle after, `Out_Valid`=0 regardless of `Out_Ready`.
- Upstream must hold `In_Valid`/payload until accepted. Downstream may drop `Out_Ready` at any cycle.

## Structure
- Shared package `pipe_pkg` holds:
  - stage control widths: WB_CTRL_W=2 (RegWrite, MemtoReg), MEM_CTRL_W=3 (Branch, MemRead, MemWrite), EX_CTRL_W;
  - the state encoding localparams EMPTY=2'd0, FULL=2'd1, SKID=2'd2.
- One natural sub-module: `pipe_slot`, a single {ctrl, data, valid} register with load and clear. It is instantiated as the main entry and, under `generate` when SKID=1, as the skid entry.

## Test plan
- Reset then stream, SKID=1, `Out_Ready`=1: beats 0x11..0x15 with ctrl 5'b10101 → `Out_Data` shows 0x11..0x15 on consecutive cycles, each one cycle after acceptance, with `Occupancy`=1 throughout.
- Stall: push 0xA, 0xB, 0xC and drop `Out_Ready` after 0xA is presented → 0xB is held in skid, `Occupancy`=2, `In_Ready`=0 and 0xC waits. On release, output order is 0xA, 0xB, 0xC with nothing lost.
- Flush in SKID state while `In_Valid`=1 with 0xD → next cycle `Out_Valid`=0, `Out_Ctrl`=0, `Occupancy`=0, and 0xD never appears.
- SKID=0, `Out_Ready` toggling 1,0,1,0: `In_Ready` tracks ~`Out_Valid` | `Out_Ready` in the same cycle, and beats 0x1..0x4 appear in order.
- Async reset asserted between clock edges while FULL → `Out_Valid` and `Out_Ctrl` go to 0 before the next edge, and `In_Ready` returns to 1 on the first cycle after release.
- Bubble check: ctrl 5'b11111 accepted, then `In_Valid`=0 → after the beat drains, `Out_Ctrl`=0 while `Out_Data` keeps the last value.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: per-stage control widths and the stage-register state encoding.
package pipe_pkg;

    localparam int WB_CTRL_W     = 2;  // RegWrite, MemtoReg
    localparam int MEM_CTRL_W    = 3;  // Branch, MemRead, MemWrite
    localparam int EX_CTRL_W     = 4;  // RegDst, ALUOp[1:0], ALUSrc
    localparam int EX_MEM_CTRL_W = WB_CTRL_W + MEM_CTRL_W;
    localparam int ID_EX_CTRL_W  = EX_CTRL_W + EX_MEM_CTRL_W;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] FULL  = 2'd1;
    localparam logic [1:0] SKID  = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = EMPTY,
        ST_FULL  = FULL,
        ST_SKID  = SKID
    } stage_state_e;

endpackage

// File: rtl/pipe_slot.sv
// Single {valid, ctrl, data} holding register with load and clear.
module pipe_slot #(
    parameter int CTRL_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Load,
    input  logic              Clear,
    input  logic [CTRL_W-1:0] D_Ctrl,
    input  logic [DATA_W-1:0] D_Data,
    output logic              Q_Valid,
    output logic [CTRL_W-1:0] Q_Ctrl,
    output logic [DATA_W-1:0] Q_Data
);

    logic              valid_r;
    logic [CTRL_W-1:0] ctrl_r;
    logic [DATA_W-1:0] data_r;

    // Clear only drops validity so the payload keeps its last value
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            valid_r <= 1'b0;
            ctrl_r  <= '0;
            data_r  <= '0;
        end else if (Clear) begin
            valid_r <= 1'b0;
        end else if (Load) begin
            valid_r <= 1'b1;
            ctrl_r  <= D_Ctrl;
            data_r  <= D_Data;
        end
    end

    assign Q_Valid = valid_r;
    assign Q_Ctrl  = ctrl_r;
    assign Q_Data  = data_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with flush, zeroed bubble control and optional skid entry.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = pipe_pkg::EX_MEM_CTRL_W,
    parameter int SKID   = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [DATA_W-1:0] Out_Data,
    output logic [1:0]        Occupancy
);

    import pipe_pkg::*;

    stage_state_e      state_r, state_nxt_s;
    logic              main_valid_s, skid_valid_s;
    logic [CTRL_W-1:0] main_ctrl_s, skid_ctrl_s, main_d_ctrl_s;
    logic [DATA_W-1:0] main_data_s, skid_data_s, main_d_data_s;
    logic              in_ready_s, in_fire_s, out_fire_s;
    logic              load_main_s, load_skid_s, clr_main_s, clr_skid_s, main_from_skid_s;

    generate
        if (SKID != 0) begin : g_skid
            // Ready depends only on flop state, never on Out_Ready
            assign in_ready_s = Reset_n & ~skid_valid_s;

            pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .Clk     (Clk),
                .Reset_n (Reset_n),
                .Load    (load_skid_s),
                .Clear   (clr_skid_s),
                .D_Ctrl  (In_Ctrl),
                .D_Data  (In_Data),
                .Q_Valid (skid_valid_s),
                .Q_Ctrl  (skid_ctrl_s),
                .Q_Data  (skid_data_s)
            );
        end else begin : g_noskid
            assign in_ready_s   = Reset_n & (~main_valid_s | Out_Ready);
            assign skid_valid_s = 1'b0;
            assign skid_ctrl_s  = '0;
            assign skid_data_s  = '0;
        end
    endgenerate

    assign in_fire_s     = In_Valid & in_ready_s;
    assign out_fire_s    = main_valid_s & Out_Ready;
    assign main_d_ctrl_s = main_from_skid_s ? skid_ctrl_s : In_Ctrl;
    assign main_d_data_s = main_from_skid_s ? skid_data_s : In_Data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Load    (load_main_s),
        .Clear   (clr_main_s),
        .D_Ctrl  (main_d_ctrl_s),
        .D_Data  (main_d_data_s),
        .Q_Valid (main_valid_s),
        .Q_Ctrl  (main_ctrl_s),
        .Q_Data  (main_data_s)
    );

    // Next-state and entry load/clear decode; Flush overrides every transition
    always_comb begin
        state_nxt_s      = state_r;
        load_main_s      = 1'b0;
        load_skid_s      = 1'b0;
        clr_main_s       = 1'b0;
        clr_skid_s       = 1'b0;
        main_from_skid_s = 1'b0;
        if (Flush) begin
            state_nxt_s = ST_EMPTY;
            clr_main_s  = 1'b1;
            clr_skid_s  = 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_nxt_s = ST_FULL;
                        load_main_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (in_fire_s && out_fire_s) begin
                        load_main_s = 1'b1;
                    end else if (in_fire_s && (SKID != 0)) begin
                        state_nxt_s = ST_SKID;
                        load_skid_s = 1'b1;
                    end else if (out_fire_s) begin
                        state_nxt_s = ST_EMPTY;
                        clr_main_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (out_fire_s) begin
                        state_nxt_s      = ST_FULL;
                        load_main_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                        clr_skid_s       = 1'b1;
                    end else begin
                        state_nxt_s = ST_SKID;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                    clr_main_s  = 1'b1;
                    clr_skid_s  = 1'b1;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    assign In_Ready  = in_ready_s;
    assign Out_Valid = main_valid_s;
    assign Out_Ctrl  = main_ctrl_s & {CTRL_W{main_valid_s}};
    assign Out_Data  = main_data_s;
    assign Occupancy = state_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table on the skid variant, hand sequences, and random traffic on both variants against a queue model.
module tb_pipe_stage_reg;

    typedef struct {
        logic        iv;
        logic [4:0]  ic;
        logic [31:0] id;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic [4:0]  ec;
        logic [31:0] ed;
        logic [1:0]  eo;
        logic        eir;
    } vec_t;

    typedef struct {
        logic [4:0]  ctrl;
        logic [31:0] data;
    } beat_t;

    localparam int NV = 25;

    logic clk, rst_n;
    logic iv1, fl1, or1, ir1, ov1;
    logic [4:0] ic1, oc1;
    logic [31:0] id1, od1;
    logic [1:0] occ1;
    logic iv0, fl0, or0, ir0, ov0;
    logic [4:0] ic0, oc0;
    logic [31:0] id0, od0;
    logic [1:0] occ0;

    int checks, errors;
    vec_t tv[NV];
    beat_t q1[$], q0[$];
    logic [31:0] last1, last0;
    logic [31:0] got0[$];
    logic acc1, acc0;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(5), .SKID(1)) dut1 (
        .Clk(clk), .Reset_n(rst_n), .Flush(fl1), .In_Valid(iv1), .In_Ready(ir1),
        .In_Ctrl(ic1), .In_Data(id1), .Out_Valid(ov1), .Out_Ready(or1),
        .Out_Ctrl(oc1), .Out_Data(od1), .Occupancy(occ1)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(5), .SKID(0)) dut0 (
        .Clk(clk), .Reset_n(rst_n), .Flush(fl0), .In_Valid(iv0), .In_Ready(ir0),
        .In_Ctrl(ic0), .In_Data(id0), .Out_Valid(ov0), .Out_Ready(or0),
        .Out_Ctrl(oc0), .Out_Data(od0), .Occupancy(occ0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic sv(input int i, input logic iv, input logic [4:0] ic, input logic [31:0] id,
                      input logic ordy, input logic fl, input logic ev, input logic [4:0] ec,
                      input logic [31:0] ed, input logic [1:0] eo, input logic eir);
        tv[i] = '{iv, ic, id, ordy, fl, ev, ec, ed, eo, eir};
    endtask

    task automatic model_reset();
        q1.delete();
        q0.delete();
        last1 = 32'd0;
        last0 = 32'd0;
        acc1 = 1'b0;
        acc0 = 1'b0;
    endtask

    task automatic chk_in_reset(input string tag);
        chk({tag, "_v1"}, {31'd0, ov1}, 32'd0);
        chk({tag, "_c1"}, {27'd0, oc1}, 32'd0);
        chk({tag, "_d1"}, od1, 32'd0);
        chk({tag, "_o1"}, {30'd0, occ1}, 32'd0);
        chk({tag, "_r1"}, {31'd0, ir1}, 32'd0);
        chk({tag, "_v0"}, {31'd0, ov0}, 32'd0);
        chk({tag, "_c0"}, {27'd0, oc0}, 32'd0);
        chk({tag, "_d0"}, od0, 32'd0);
        chk({tag, "_o0"}, {30'd0, occ0}, 32'd0);
        chk({tag, "_r0"}, {31'd0, ir0}, 32'd0);
    endtask

    // Mid-cycle: compare both DUTs with the queue model and note handshakes
    task automatic sample_check();
        @(negedge clk);
        chk("s1_valid", {31'd0, ov1}, (q1.size() > 0) ? 32'd1 : 32'd0);
        chk("s1_ctrl", {27'd0, oc1}, (q1.size() > 0) ? {27'd0, q1[0].ctrl} : 32'd0);
        chk("s1_data", od1, (q1.size() > 0) ? q1[0].data : last1);
        chk("s1_occ", {30'd0, occ1}, q1.size());
        chk("s1_inrdy", {31'd0, ir1}, (q1.size() < 2) ? 32'd1 : 32'd0);
        chk("s0_valid", {31'd0, ov0}, (q0.size() > 0) ? 32'd1 : 32'd0);
        chk("s0_ctrl", {27'd0, oc0}, (q0.size() > 0) ? {27'd0, q0[0].ctrl} : 32'd0);
        chk("s0_data", od0, (q0.size() > 0) ? q0[0].data : last0);
        chk("s0_occ", {30'd0, occ0}, q0.size());
        chk("s0_inrdy", {31'd0, ir0}, ((q0.size() == 0) || or0) ? 32'd1 : 32'd0);
        acc1 = iv1 & ir1;
        acc0 = iv0 & ir0;
        if (ov0 && or0) got0.push_back(od0);
    endtask

    // Clock edge: advance the model using the inputs that were applied this cycle
    task automatic advance();
        bit inf, outf;
        @(posedge clk);
        inf  = iv1 && (q1.size() < 2);
        outf = (q1.size() > 0) && or1;
        if (fl1) q1.delete();
        else begin
            if (outf) void'(q1.pop_front());
            if (inf) q1.push_back('{ic1, id1});
        end
        if (q1.size() > 0) last1 = q1[0].data;
        inf  = iv0 && ((q0.size() == 0) || or0);
        outf = (q0.size() > 0) && or0;
        if (fl0) q0.delete();
        else begin
            if (outf) void'(q0.pop_front());
            if (inf) q0.push_back('{ic0, id0});
        end
        if (q0.size() > 0) last0 = q0[0].data;
        #1;
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        {iv1, fl1, or1, ic1, id1} = '0;
        {iv0, fl0, or0, ic0, id0} = '0;
        model_reset();

        //            iv  ic     id      or fl | ev ec     ed      eo    eir
        sv( 0, 1'b1, 5'h15, 32'h11, 1'b1, 1'b0, 1'b0, 5'h00, 32'h00, 2'd0, 1'b1);
        sv( 1, 1'b1, 5'h15, 32'h12, 1'b1, 1'b0, 1'b1, 5'h15, 32'h11, 2'd1, 1'b1);
        sv( 2, 1'b1, 5'h15, 32'h13, 1'b1, 1'b0, 1'b1, 5'h15, 32'h12, 2'd1, 1'b1);
        sv( 3, 1'b1, 5'h15, 32'h14, 1'b1, 1'b0, 1'b1, 5'h15, 32'h13, 2'd1, 1'b1);
        sv( 4, 1'b1, 5'h15, 32'h15, 1'b1, 1'b0, 1'b1, 5'h15, 32'h14, 2'd1, 1'b1);
        sv( 5, 1'b0, 5'h00, 32'h00, 1'b1, 1'b0, 1'b1, 5'h15, 32'h15, 2'd1, 1'b1);
        sv( 6, 1'b0, 5'h00, 32'h00, 1'b1, 1'b0, 1'b0, 5'h00, 32'h15, 2'd0, 1'b1);
        sv( 7, 1'b1, 5'h03, 32'h0A, 1'b1, 1'b0, 1'b0, 5'h00, 32'h15, 2'd0, 1'b1);
        sv( 8, 1'b1, 5'h03, 32'h0B, 1'b0, 1'b0, 1'b1, 5'h03, 32'h0A, 2'd1, 1'b1);
        sv( 9, 1'b1, 5'h03, 32'h0C, 1'b0, 1'b0, 1'b1, 5'h03, 32'h0A, 2'd2, 1'b0);
        sv(10, 1'b1, 5'h03, 32'h0C, 1'b0, 1'b0, 1'b1, 5'h03, 32'h0A, 2'd2, 1'b0);
        sv(11, 1'b1, 5'h03, 32'h0C, 1'b1, 1'b0, 1'b1, 5'h03, 32'h0A, 2'd2, 1'b0);
        sv(12, 1'b1, 5'h03, 32'h0C, 1'b1, 1'b0, 1'b1, 5'h03, 32'h0B, 2'd1, 1'b1);
        sv(13, 1'b0, 5'h00, 32'h00, 1'b1, 1'b0, 1'b1, 5'h03, 32'h0C, 2'd1, 1'b1);
        sv(14, 1'b0, 5'h00, 32'h00, 1'b1, 1'b0, 1'b0, 5'h00, 32'h0C, 2'd0, 1'b1);
        sv(15, 1'b1, 5'h07, 32'h21, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0C, 2'd0, 1'b1);
        sv(16, 1'b1, 5'h07, 32'h22, 1'b0, 1'b0, 1'b1, 5'h07, 32'h21, 2'd1, 1'b1);
        sv(17, 1'b1, 5'h07, 32'h0D, 1'b0, 1'b1, 1'b1, 5'h07, 32'h21, 2'd2, 1'b0);
        sv(18, 1'b0, 5'h00, 32'h00, 1'b0, 1'b0, 1'b0, 5'h00, 32'h21, 2'd0, 1'b1);
        sv(19, 1'b1, 5'h01, 32'h31, 1'b1, 1'b0, 1'b0, 5'h00, 32'h21, 2'd0, 1'b1);
        sv(20, 1'b1, 5'h01, 32'h32, 1'b1, 1'b1, 1'b1, 5'h01, 32'h31, 2'd1, 1'b1);
        sv(21, 1'b0, 5'h00, 32'h00, 1'b1, 1'b0, 1'b0, 5'h00, 32'h31, 2'd0, 1'b1);
        sv(22, 1'b1, 5'h1F, 32'h5A, 1'b1, 1'b0, 1'b0, 5'h00, 32'h31, 2'd0, 1'b1);
        sv(23, 1'b0, 5'h00, 32'h00, 1'b1, 1'b0, 1'b1, 5'h1F, 32'h5A, 2'd1, 1'b1);
        sv(24, 1'b0, 5'h00, 32'h00, 1'b1, 1'b0, 1'b0, 5'h00, 32'h5A, 2'd0, 1'b1);

        #12;
        chk_in_reset("por");
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("por_rel_r1", {31'd0, ir1}, 32'd1);
        chk("por_rel_r0", {31'd0, ir0}, 32'd1);
        model_reset();

        or0 = 1'b1;
        for (int i = 0; i < NV; i++) begin
            iv1 = tv[i].iv; ic1 = tv[i].ic; id1 = tv[i].id; or1 = tv[i].ordy; fl1 = tv[i].fl;
            sample_check();
            chk($sformatf("t%0d_valid", i), {31'd0, ov1}, {31'd0, tv[i].ev});
            chk($sformatf("t%0d_ctrl", i), {27'd0, oc1}, {27'd0, tv[i].ec});
            chk($sformatf("t%0d_data", i), od1, tv[i].ed);
            chk($sformatf("t%0d_occ", i), {30'd0, occ1}, {30'd0, tv[i].eo});
            chk($sformatf("t%0d_inrdy", i), {31'd0, ir1}, {31'd0, tv[i].eir});
            advance();
        end

        // Non-skid variant with Out_Ready toggling every cycle
        got0.delete();
        iv0 = 1'b1; ic0 = 5'h06; id0 = 32'd1; n = 1; acc0 = 1'b0;
        for (int c = 0; c < 20 && got0.size() < 4; c++) begin
            if (acc0) begin
                if (n < 4) begin n++; id0 = n; end
                else iv0 = 1'b0;
            end
            or0 = (c % 2 == 0);
            sample_check();
            advance();
        end
        chk("s0_order_cnt", got0.size(), 32'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("s0_order%0d", k), (k < got0.size()) ? got0[k] : 32'hFFFF_FFFF, k + 1);
        iv0 = 1'b0; or0 = 1'b1;
        repeat (2) begin sample_check(); advance(); end

        // Asynchronous reset between edges while both stages are full
        iv1 = 1'b1; ic1 = 5'h1F; id1 = 32'h77; or1 = 1'b0; fl1 = 1'b0;
        iv0 = 1'b1; ic0 = 5'h0F; id0 = 32'h66; or0 = 1'b0; fl0 = 1'b0;
        sample_check();
        advance();
        iv1 = 1'b0; iv0 = 1'b0;
        sample_check();
        #2 rst_n = 1'b0;
        #1;
        chk_in_reset("arst");
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("arst_rel_r1", {31'd0, ir1}, 32'd1);
        chk("arst_rel_r0", {31'd0, ir0}, 32'd1);
        model_reset();

        // Random traffic; upstream holds each beat until the DUT accepts it
        for (int c = 0; c < 600; c++) begin
            if (!iv1 || acc1) begin
                iv1 = ($urandom_range(0, 3) != 0); ic1 = 5'($urandom); id1 = $urandom;
            end
            if (!iv0 || acc0) begin
                iv0 = ($urandom_range(0, 3) != 0); ic0 = 5'($urandom); id0 = $urandom;
            end
            or1 = ($urandom_range(0, 9) < 6);
            or0 = ($urandom_range(0, 9) < 6);
            fl1 = ($urandom_range(0, 19) == 0);
            fl0 = ($urandom_range(0, 19) == 0);
            sample_check();
            advance();
        end
        iv1 = 1'b0; iv0 = 1'b0; fl1 = 1'b0; fl0 = 1'b0; or1 = 1'b1; or0 = 1'b1;
        repeat (3) begin sample_check(); advance(); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
